// File: rtl/cfar_frame_parser_if.sv
// rtl/cfar_frame_parser_if.sv - input word stream and extracted payload stream of the frame parser
interface cfar_frame_parser_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic [31:0] m_data;
    logic [7:0]  m_idx;
    logic        m_last;

    modport master (
        output s_valid, s_data, s_last,
        input  m_valid, m_data, m_idx, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output m_valid, m_data, m_idx, m_last
    );
endinterface

// File: rtl/cfar_frame_parser.sv
// rtl/cfar_frame_parser.sv - framed word stream parser: header/info/payload/trailer checks, payload extraction
module cfar_frame_parser #(
    parameter int          PAYLOAD_LEN = 1024,
    parameter logic [31:0] HDR_WORD    = 32'hA5A5A5A5,
    parameter logic [31:0] TRL_WORD    = 32'hF0F0F0F0
) (
    input  logic                 clk,
    input  logic                 rst,
    cfar_frame_parser_if.slave   bus,
    output logic [23:0]          frame_cnt_o,
    output logic [7:0]           valid_num_o,
    output logic                 frame_ok,
    output logic                 hdr_err,
    output logic                 len_err,
    output logic                 seq_err,
    output logic [15:0]          ok_count,
    output logic [15:0]          err_count
);
    localparam int CW = 12;
    localparam logic [CW-1:0] PLEN     = CW'(PAYLOAD_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        ST_DISCARD = 3'd0,
        ST_IDLE    = 3'd1,
        ST_INFO    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRL1    = 3'd4,
        ST_TRL2    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    vnum_q, vnum_d;
    logic [23:0]   fcnt_q, fcnt_d;
    logic [23:0]   prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic [7:0]    m_idx_q, m_idx_d;
    logic          m_last_q, m_last_d;
    logic          ok_q, ok_d, hdr_q, hdr_d, len_q, len_d, seq_q, seq_d;
    logic [15:0]   ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
    logic [CW-1:0] limit;
    state_t        err_next;

    // Number of payload words actually forwarded: min(valid_num, PAYLOAD_LEN).
    assign limit    = ({4'b0, vnum_q} < PLEN) ? {4'b0, vnum_q} : PLEN;
    assign err_next = (!bus.s_valid || bus.s_last) ? ST_IDLE : ST_DISCARD;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vnum_d      = vnum_q;
        fcnt_d      = fcnt_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        m_valid_d   = 1'b0;
        m_data_d    = m_data_q;
        m_idx_d     = m_idx_q;
        m_last_d    = 1'b0;
        ok_d        = 1'b0;
        hdr_d       = 1'b0;
        len_d       = 1'b0;
        seq_d       = 1'b0;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_DISCARD: begin
                if (!bus.s_valid || bus.s_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.s_valid) begin
                    if (bus.s_data == HDR_WORD && !bus.s_last) begin
                        state_d = ST_INFO;
                    end else begin
                        hdr_d   = 1'b1;
                        state_d = bus.s_last ? ST_IDLE : ST_DISCARD;
                    end
                end
            end
            ST_INFO: begin
                if (!bus.s_valid || bus.s_last) begin
                    len_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = bus.s_data[23:0];
                    vnum_d  = bus.s_data[31:24];
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!bus.s_valid || bus.s_last) begin
                    len_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q < limit) begin
                        m_valid_d = 1'b1;
                        m_data_d  = bus.s_data;
                        m_idx_d   = cnt_q[7:0];
                        m_last_d  = (cnt_q == limit - 1'b1);
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = ST_TRL1;
                end
            end
            ST_TRL1: begin
                if (!bus.s_valid || bus.s_last || bus.s_data != TRL_WORD) begin
                    len_d   = 1'b1;
                    state_d = err_next;
                end else begin
                    state_d = ST_TRL2;
                end
            end
            ST_TRL2: begin
                if (bus.s_valid && bus.s_last && bus.s_data == TRL_WORD) begin
                    ok_d        = 1'b1;
                    seq_d       = have_prev_q && (fcnt_q != prev_q + 24'd1);
                    prev_d      = fcnt_q;
                    have_prev_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    len_d   = 1'b1;
                    state_d = err_next;
                end
            end
            default: state_d = ST_DISCARD;
        endcase

        if (ok_d && ok_cnt_q != 16'hFFFF) ok_cnt_d = ok_cnt_q + 16'd1;
        if ((hdr_d || len_d) && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_DISCARD;
            cnt_q       <= '0;
            vnum_q      <= '0;
            fcnt_q      <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_idx_q     <= '0;
            m_last_q    <= 1'b0;
            ok_q        <= 1'b0;
            hdr_q       <= 1'b0;
            len_q       <= 1'b0;
            seq_q       <= 1'b0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vnum_q      <= vnum_d;
            fcnt_q      <= fcnt_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_idx_q     <= m_idx_d;
            m_last_q    <= m_last_d;
            ok_q        <= ok_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_idx   = m_idx_q;
    assign bus.m_last  = m_last_q;
    assign frame_cnt_o = fcnt_q;
    assign valid_num_o = vnum_q;
    assign frame_ok    = ok_q;
    assign hdr_err     = hdr_q;
    assign len_err     = len_q;
    assign seq_err     = seq_q;
    assign ok_count    = ok_cnt_q;
    assign err_count   = err_cnt_q;
endmodule
